// File: rtl/line_clear_pkg.sv
// line_clear_pkg: board geometry, widths and FSM state codes shared by the line-clear engine.
package tetris_pkg;
    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int XW      = 4;
    localparam int YW      = 5;
    localparam int SCORE_W = 5;
    typedef logic [2:0] state_t;
    localparam state_t IDLE  = 3'd0;
    localparam state_t READ  = 3'd1;
    localparam state_t EVAL  = 3'd2;
    localparam state_t WRITE = 3'd3;
    localparam state_t NEXT  = 3'd4;
    localparam state_t CLEAR = 3'd5;
    localparam state_t DONE  = 3'd6;
endpackage

// File: rtl/line_clear_rowbuf.sv
// line_clear_rowbuf: shifts in one row of cells, x=0 first, and flags a full row.
module line_clear_rowbuf
    import tetris_pkg::*;
(
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            shift_i,
    input  logic            bit_i,
    output logic [COLS-1:0] row_o,
    output logic            full_o
);
    logic [COLS-1:0] row_q, row_d;
    // After COLS shifts the first cell read sits in bit 0, so row_o[x] is cell x.
    assign row_d  = shift_i ? {bit_i, row_q[COLS-1:1]} : row_q;
    assign row_o  = row_q;
    assign full_o = &row_q;
    always_ff @(posedge clk_i) begin
        if (!resetn_i) row_q <= '0;
        else           row_q <= row_d;
    end
endmodule

// File: rtl/line_clear.sv
// line_clear: removes full rows from the board, compacts the rest downward and keeps the score.
module line_clear
    import tetris_pkg::*;
(
    input  logic               CLOCK_50_i,
    input  logic               resetn_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [XW-1:0]      rd_x_o,
    output logic [YW-1:0]      rd_y_o,
    input  logic               rd_data_i,
    output logic               we_o,
    output logic [XW-1:0]      wr_x_o,
    output logic [YW-1:0]      wr_y_o,
    output logic               wr_data_o,
    output logic [YW-1:0]      lines_o,
    output logic [SCORE_W-1:0] score_o
);
    state_t             state_q, state_d;
    logic [YW-1:0]      src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, lines_q, lines_d;
    logic [XW-1:0]      x_q, x_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;
    logic [COLS-1:0]    row;
    logic               full;

    line_clear_rowbuf u_rowbuf (
        .clk_i    (CLOCK_50_i),
        .resetn_i (resetn_i),
        .shift_i  (state_q == READ && x_q != '0),
        .bit_i    (rd_data_i),
        .row_o    (row),
        .full_o   (full)
    );

    assign sum = {1'b0, score_q} + (SCORE_W+1)'(cnt_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        lines_d = lines_q;
        score_d = score_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = READ;
                src_d   = YW'(ROWS-1);
                dst_d   = YW'(ROWS-1);
                cnt_d   = '0;
                x_d     = '0;
            end
            READ: begin
                x_d     = x_q == XW'(COLS) ? '0 : x_q + 1'b1;
                state_d = x_q == XW'(COLS) ? EVAL : READ;
            end
            // Rows that stay put or vanish advance straight to the next read.
            EVAL: if (!full && src_q != dst_q) state_d = WRITE;
            else begin
                cnt_d   = cnt_q + YW'(full);
                dst_d   = full ? dst_q : dst_q - 1'b1;
                src_d   = src_q == '0 ? src_q : src_q - 1'b1;
                state_d = src_q != '0 ? READ : (cnt_d == '0 ? DONE : CLEAR);
            end
            WRITE: begin
                x_d     = x_q == XW'(COLS-1) ? '0 : x_q + 1'b1;
                dst_d   = x_q == XW'(COLS-1) ? dst_q - 1'b1 : dst_q;
                state_d = x_q == XW'(COLS-1) ? NEXT : WRITE;
            end
            NEXT: begin
                src_d   = src_q == '0 ? src_q : src_q - 1'b1;
                state_d = src_q != '0 ? READ : (cnt_q == '0 ? DONE : CLEAR);
            end
            CLEAR: if (x_q == XW'(COLS-1)) begin
                x_d     = '0;
                dst_d   = dst_q - 1'b1;
                state_d = dst_q == '0 ? DONE : CLEAR;
            end else x_d = x_q + 1'b1;
            DONE: begin
                lines_d = cnt_q;
                score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            src_q   <= YW'(ROWS-1);
            dst_q   <= YW'(ROWS-1);
            cnt_q   <= '0;
            x_q     <= '0;
            lines_q <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            lines_q <= lines_d;
            score_q <= score_d;
        end
    end

    assign busy_o    = state_q != IDLE && state_q != DONE;
    assign done_o    = state_q == DONE;
    assign rd_x_o    = (state_q == READ && x_q != XW'(COLS)) ? x_q : '0;
    assign rd_y_o    = state_q == READ ? src_q : '0;
    assign we_o      = state_q == WRITE || state_q == CLEAR;
    assign wr_x_o    = we_o ? x_q : '0;
    assign wr_y_o    = we_o ? dst_q : '0;
    assign wr_data_o = state_q == WRITE ? row[x_q] : 1'b0;
    assign lines_o   = lines_q;
    assign score_o   = score_q;
endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear: board RAM model plus a row-compaction reference model checking line_clear.
module tb_line_clear;
    import tetris_pkg::*;
    logic       clk = 0, resetn = 0, start = 0, rd_data = 0, load = 0;
    logic       busy, done, we, wr_data;
    logic [3:0] rd_x, wr_x;
    logic [4:0] rd_y, wr_y, lines, score;
    logic [9:0] board[20], load_img[20], expb[20];
    logic       read_row[20];
    int checks = 0, failures = 0, we_cnt = 0, done_cnt = 0;
    int exp_score = 0, exp_cnt, exp_moved, cyc;

    always #10 clk = ~clk;

    line_clear dut (
        .CLOCK_50_i(clk), .resetn_i(resetn), .start_i(start),
        .busy_o(busy), .done_o(done), .rd_x_o(rd_x), .rd_y_o(rd_y), .rd_data_i(rd_data),
        .we_o(we), .wr_x_o(wr_x), .wr_y_o(wr_y), .wr_data_o(wr_data),
        .lines_o(lines), .score_o(score)
    );

    // Registered-read board RAM.
    always @(posedge clk) begin
        if (load) board <= load_img;
        else if (we && wr_y < 20 && wr_x < 10) board[wr_y][wr_x] <= wr_data;
        rd_data <= (rd_y < 20 && rd_x < 10) ? board[rd_y][rd_x] : 1'b0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Per-cycle protocol checks: writes only while busy, only to rows already read.
    always @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 20; i++) read_row[i] = 0;
        end else begin
            if (we) we_cnt++;
            if (done) done_cnt++;
            if (busy && rd_x == 9 && rd_y < 20) read_row[rd_y] = 1;
            if (we) begin
                chk("we_while_busy", int'(busy), 1);
                chk("write_after_read", (wr_y < 20) ? int'(read_row[wr_y]) : 0, 1);
            end
            if (done) begin
                chk("done_not_busy", int'(busy), 0);
                for (int i = 0; i < 20; i++) read_row[i] = 0;
            end
        end
    end

    // Reference: keep non-full rows in bottom-up order, zero-fill the top.
    task automatic model();
        int d = 19;
        exp_cnt = 0;
        exp_moved = 0;
        for (int i = 19; i >= 0; i--) begin
            if (load_img[i] == 10'h3FF) exp_cnt++;
            else begin
                expb[d] = load_img[i];
                if (d != i) exp_moved++;
                d--;
            end
        end
        for (int i = d; i >= 0; i--) expb[i] = '0;
    endtask

    task automatic load_board();
        @(negedge clk) load = 1;
        @(negedge clk) load = 0;
    endtask

    task automatic run_pass(input string nm, input bit mid_start);
        int we0 = we_cnt, d0 = done_cnt;
        bit pulsed = 0;
        load_board();
        model();
        @(negedge clk) start = 1;
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 0;
            if (done) break;
            if (mid_start && !pulsed && we) begin
                start = 1;
                pulsed = 1;
            end
        end
        chk({nm, "_done_seen"}, int'(done), 1);
        repeat (mid_start ? 300 : 3) @(negedge clk);
        exp_score = (exp_score + exp_cnt > 31) ? 31 : exp_score + exp_cnt;
        chk({nm, "_cycles"}, cyc, 12 * ROWS + 11 * exp_moved + 10 * exp_cnt + 1);
        chk({nm, "_lines"}, int'(lines), exp_cnt);
        chk({nm, "_score"}, int'(score), exp_score);
        chk({nm, "_we_cycles"}, we_cnt - we0, 10 * (exp_moved + exp_cnt));
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
        chk({nm, "_busy_after"}, int'(busy), 0);
        for (int i = 0; i < 20; i++) chk($sformatf("%s_row%0d", nm, i), int'(board[i]), int'(expb[i]));
    endtask

    initial begin
        for (int i = 0; i < 20; i++) load_img[i] = '0;
        repeat (3) @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_rd_x", int'(rd_x), 0);
        chk("rst_rd_y", int'(rd_y), 0);
        chk("rst_wr_x", int'(wr_x), 0);
        chk("rst_wr_y", int'(wr_y), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_lines", int'(lines), 0);
        chk("rst_score", int'(score), 0);

        run_pass("empty", 0);
        chk("empty_cycles_lit", cyc, 241);

        for (int i = 0; i < 20; i++) load_img[i] = '0;
        load_img[19] = 10'h3FF;
        load_img[18] = 10'h003;
        run_pass("one", 0);
        chk("one_row19_lit", int'(board[19]), 'h003);
        chk("one_score_lit", int'(score), 1);

        for (int i = 0; i < 20; i++) load_img[i] = (i >= 16) ? 10'h3FF : 10'h000;
        load_img[15] = 10'h010;
        run_pass("four", 0);
        chk("four_row19_lit", int'(board[19]), 'h010);
        chk("four_lines_lit", int'(lines), 4);

        for (int i = 0; i < 20; i++) load_img[i] = '0;
        load_img[19] = 10'h3FF;
        load_img[18] = 10'h155;
        load_img[17] = 10'h3FF;
        load_img[16] = 10'h2AA;
        load_img[3]  = 10'h201;
        run_pass("gap", 1);
        chk("gap_row19_lit", int'(board[19]), 'h155);
        chk("gap_row18_lit", int'(board[18]), 'h2AA);
        chk("gap_row5_lit", int'(board[5]), 'h201);

        for (int i = 0; i < 20; i++) load_img[i] = 10'h3FF;
        run_pass("all", 0);
        chk("all_lines_lit", int'(lines), 20);

        for (int i = 0; i < 20; i++) load_img[i] = (i >= 17) ? 10'h3FF : 10'(i * 37);
        run_pass("three", 0);
        chk("three_score_lit", int'(score), 30);

        for (int i = 0; i < 20; i++) load_img[i] = '0;
        load_img[19] = 10'h3FF;
        load_img[10] = 10'h3FF;
        load_img[12] = 10'h0F0;
        run_pass("sat", 0);
        chk("sat_score_lit", int'(score), 31);
        chk("sat_lines_lit", int'(lines), 2);

        for (int i = 0; i < 20; i++) load_img[i] = '0;
        load_img[19] = 10'h3FF;
        load_img[18] = 10'h1C3;
        load_board();
        @(negedge clk) start = 1;
        cyc = 0;
        @(negedge clk) start = 0;
        while (!we && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_write_reached", int'(we), 1);
        resetn = 0;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_we", int'(we), 0);
        chk("mid_rst_score", int'(score), 0);
        chk("mid_rst_lines", int'(lines), 0);
        resetn = 1;
        exp_score = 0;

        for (int i = 0; i < 20; i++) load_img[i] = '0;
        load_img[19] = 10'h3FF;
        run_pass("after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
